// File: rtl/rom_loader_pkg.sv
// Shared types and region map for the ROM download front end.
// Region bounds are 17-bit byte addresses within the downloaded image.
package rom_loader_pkg;

    localparam logic [16:0] GFX1_BASE = 17'h0A000;
    localparam logic [16:0] GFX2_BASE = 17'h10000;
    localparam logic [16:0] PROM_BASE = 17'h1C000;
    localparam logic [16:0] PROM_END  = 17'h1C320;

    typedef enum logic [1:0] {P1, P2, DL, DROP} region_t;

    typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_W1, ST_W2} state_t;

    function automatic region_t decode_region(input logic [16:0] a);
        region_t r;
        if (a < GFX1_BASE)
            r = P1;
        else if (a < GFX2_BASE)
            r = DL;
        else if (a < PROM_BASE)
            r = P2;
        else if (a < PROM_END)
            r = DL;
        else
            r = DROP;
        return r;
    endfunction

endpackage

// File: rtl/rom_loader_byte_fifo.sv
// Small synchronous FIFO with occupancy count; push when full and pop when
// empty are ignored, so callers decide what a rejected push means.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)
                r_count <= r_count + CW'(1);
            else if (w_pop_ok && !w_push_ok)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ioctl download front end: buffers bytes, routes them to SDRAM port1/port2
// or the local dl bus, and owns rom_loaded and the post-load core reset.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_HOLD = 16'hFFFF,
    parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    input  logic        soft_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_wr_d;
    logic          r_dl_d;
    logic          r_dl_pending;
    logic          r_p1_req, r_p2_req;
    logic [22:0]   r_p1_a, r_p2_a;
    logic [1:0]    r_p1_ds, r_p2_ds;
    logic [15:0]   r_p1_d, r_p2_d;
    logic          r_p1_we, r_p2_we;
    logic          r_dl_wr;
    logic [16:0]   r_dl_addr;
    logic [7:0]    r_dl_data;
    logic          r_rom_loaded;
    logic          r_overflow;
    logic [15:0]   r_hold;

    logic          w_wr_rise;
    logic          w_push;
    logic          w_pop;
    logic          w_full, w_empty;
    logic [CW-1:0] w_count;
    logic [24:0]   w_head;
    logic [16:0]   w_head_addr;
    logic [7:0]    w_head_data;
    region_t       w_region;
    logic [23:0]   w_p2_off;
    logic          w_issue_p1, w_issue_p2, w_issue_dl;
    logic          w_dl_rise;
    logic          w_done;
    logic          w_unused;

    assign w_unused  = ^ioctl_addr[24:17];

    assign w_wr_rise = ioctl_wr & ~r_wr_d & ioctl_download & (ioctl_index == ROM_INDEX);
    assign w_push    = w_wr_rise & ~w_full;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (25)
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_wdata ({ioctl_addr[16:0], ioctl_dout}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_addr = w_head[24:8];
    assign w_head_data = w_head[7:0];
    assign w_region    = decode_region(w_head_addr);
    assign w_p2_off    = {7'b0, w_head_addr} - {7'b0, GFX2_BASE};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_issue_p1   = 1'b0;
        w_issue_p2   = 1'b0;
        w_issue_dl   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty)
                    w_next_state = ST_POP;
            end
            ST_POP: begin
                w_pop = 1'b1;
                case (w_region)
                    P1: begin
                        w_issue_p1   = 1'b1;
                        w_next_state = ST_W1;
                    end
                    P2: begin
                        w_issue_p2   = 1'b1;
                        w_next_state = ST_W2;
                    end
                    DL: begin
                        w_issue_dl   = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                    default: w_next_state = ST_IDLE;
                endcase
            end
            ST_W1: begin
                if (port1_ack == r_p1_req)
                    w_next_state = w_empty ? ST_IDLE : ST_POP;
            end
            ST_W2: begin
                if (port2_ack == r_p2_req)
                    w_next_state = w_empty ? ST_IDLE : ST_POP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Address/data registers only load on issue, so they hold until the ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_req  <= 1'b0;
            r_p1_a    <= '0;
            r_p1_ds   <= '0;
            r_p1_d    <= '0;
            r_p1_we   <= 1'b0;
            r_p2_req  <= 1'b0;
            r_p2_a    <= '0;
            r_p2_ds   <= '0;
            r_p2_d    <= '0;
            r_p2_we   <= 1'b0;
            r_dl_wr   <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= '0;
        end else begin
            r_dl_wr <= w_issue_dl;
            if (w_issue_dl) begin
                r_dl_addr <= w_head_addr;
                r_dl_data <= w_head_data;
            end
            if (w_issue_p1) begin
                r_p1_req <= ~r_p1_req;
                r_p1_a   <= {7'b0, w_head_addr[16:1]};
                r_p1_ds  <= {w_head_addr[0], ~w_head_addr[0]};
                r_p1_d   <= {w_head_data, w_head_data};
                r_p1_we  <= 1'b1;
            end
            if (w_issue_p2) begin
                r_p2_req <= ~r_p2_req;
                r_p2_a   <= {w_p2_off[23:16], w_p2_off[13:0], w_p2_off[15]};
                r_p2_ds  <= {w_p2_off[14], ~w_p2_off[14]};
                r_p2_d   <= {w_head_data, w_head_data};
                r_p2_we  <= 1'b1;
            end
        end
    end

    assign w_dl_rise = ioctl_download & ~r_dl_d;
    // Completion needs a download to have been seen, so power-up stays unloaded.
    assign w_done    = r_dl_pending & ~ioctl_download & w_empty & (r_state == ST_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_d       <= 1'b0;
            r_dl_d       <= 1'b0;
            r_dl_pending <= 1'b0;
            r_rom_loaded <= 1'b0;
            r_overflow   <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_wr_d <= ioctl_wr;
            r_dl_d <= ioctl_download;

            if (w_dl_rise)
                r_dl_pending <= 1'b1;
            else if (w_done)
                r_dl_pending <= 1'b0;

            if (w_dl_rise)
                r_rom_loaded <= 1'b0;
            else if (w_done)
                r_rom_loaded <= 1'b1;

            if (w_wr_rise && w_full)
                r_overflow <= 1'b1;
            else if (w_dl_rise)
                r_overflow <= 1'b0;

            if (w_done || (soft_reset && r_rom_loaded && !ioctl_download))
                r_hold <= RESET_HOLD;
            else if (r_hold != '0)
                r_hold <= r_hold - 16'd1;
        end
    end

    assign ioctl_wait = (w_count >= CW'(FIFO_DEPTH - 1));
    assign port1_req  = r_p1_req;
    assign port1_a    = r_p1_a;
    assign port1_ds   = r_p1_ds;
    assign port1_d    = r_p1_d;
    assign port1_we   = r_p1_we;
    assign port2_req  = r_p2_req;
    assign port2_a    = r_p2_a;
    assign port2_ds   = r_p2_ds;
    assign port2_d    = r_p2_d;
    assign port2_we   = r_p2_we;
    assign dl_wr      = r_dl_wr;
    assign dl_addr    = r_dl_addr;
    assign dl_data    = r_dl_data;
    assign rom_loaded = r_rom_loaded;
    assign overflow   = r_overflow;
    assign core_reset = ~r_rom_loaded | ioctl_download | (r_hold != '0);

endmodule
